// File: rtl/sdram_avalon_arbiter.sv
// Two-master round-robin Avalon-MM arbiter in front of the SDRAM controller slave port.
// Read IDs are queued so each readdatavalid is steered back to the master that issued it.
module sdram_avalon_arbiter #(
  parameter int AVS_AW      = 24,
  parameter int AVS_DW      = 16,
  parameter int AVS_BYTE    = 2,
  parameter int MAX_PENDING = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               m0_read,
  input  logic                               m0_write,
  input  logic [AVS_AW-1:0]                  m0_address,
  input  logic [AVS_DW-1:0]                  m0_writedata,
  input  logic [AVS_BYTE-1:0]                m0_byteenable,
  output logic                               m0_waitrequest,
  output logic [AVS_DW-1:0]                  m0_readdata,
  output logic                               m0_readdatavalid,
  input  logic                               m1_read,
  input  logic                               m1_write,
  input  logic [AVS_AW-1:0]                  m1_address,
  input  logic [AVS_DW-1:0]                  m1_writedata,
  input  logic [AVS_BYTE-1:0]                m1_byteenable,
  output logic                               m1_waitrequest,
  output logic [AVS_DW-1:0]                  m1_readdata,
  output logic                               m1_readdatavalid,
  output logic                               ctrl_read,
  output logic                               ctrl_write,
  output logic [AVS_AW-1:0]                  ctrl_address,
  output logic [AVS_DW-1:0]                  ctrl_writedata,
  output logic [AVS_BYTE-1:0]                ctrl_byteenable,
  input  logic                               ctrl_waitrequest,
  input  logic [AVS_DW-1:0]                  ctrl_readdata,
  input  logic                               ctrl_readdatavalid,
  output logic [$clog2(MAX_PENDING):0]       pending_cnt,
  output logic                               err_rdv
);

  localparam int PW = $clog2(MAX_PENDING);
  localparam int CW = PW + 1;

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t                 state, state_next;
  logic                   lock_id;
  logic                   rr_last;
  logic                   grant_valid;
  logic                   grant_id;
  logic                   req0, req1;
  logic                   sel_read, sel_write;
  logic                   accept, push, pop;
  logic [MAX_PENDING-1:0] id_mem;
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [CW-1:0]          count;
  logic                   fifo_full, fifo_empty, fifo_head;

  assign fifo_full  = (count == CW'(MAX_PENDING));
  assign fifo_empty = (count == '0);
  assign fifo_head  = id_mem[rd_ptr];

  // A read cannot even request while the ID FIFO is full; writes always can.
  assign req0 = m0_write | (m0_read & ~fifo_full);
  assign req1 = m1_write | (m1_read & ~fifo_full);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_IDLE;
      lock_id <= 1'b0;
      rr_last <= 1'b1;
    end else begin
      state <= state_next;
      if (grant_valid && ctrl_waitrequest)
        lock_id <= grant_id;
      if (accept)
        rr_last <= grant_id;
    end
  end

  always_comb begin
    state_next  = ST_IDLE;
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (state == ST_LOCKED) begin
      grant_id    = lock_id;
      grant_valid = lock_id ? req1 : req0;
    end else if (req0 && req1) begin
      grant_valid = 1'b1;
      grant_id    = ~rr_last;
    end else if (req0) begin
      grant_valid = 1'b1;
      grant_id    = 1'b0;
    end else if (req1) begin
      grant_valid = 1'b1;
      grant_id    = 1'b1;
    end
    if (grant_valid && ctrl_waitrequest)
      state_next = ST_LOCKED;
  end

  // Write wins over a simultaneous read from the same master.
  assign sel_write = grant_id ? m1_write : m0_write;
  assign sel_read  = grant_id ? (m1_read & ~m1_write) : (m0_read & ~m0_write);

  assign ctrl_read       = reset & grant_valid & sel_read;
  assign ctrl_write      = reset & grant_valid & sel_write;
  assign ctrl_address    = grant_id ? m1_address    : m0_address;
  assign ctrl_writedata  = grant_id ? m1_writedata  : m0_writedata;
  assign ctrl_byteenable = grant_id ? m1_byteenable : m0_byteenable;

  assign accept = reset & grant_valid & ~ctrl_waitrequest;
  assign push   = accept & sel_read;
  assign pop    = ctrl_readdatavalid & ~fifo_empty;

  assign m0_waitrequest   = ~(accept & ~grant_id);
  assign m1_waitrequest   = ~(accept & grant_id);
  assign m0_readdata      = ctrl_readdata;
  assign m1_readdata      = ctrl_readdata;
  assign m0_readdatavalid = reset & pop & ~fifo_head;
  assign m1_readdatavalid = reset & pop & fifo_head;
  assign pending_cnt      = count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      err_rdv <= 1'b0;
    end else begin
      if (push) begin
        id_mem[wr_ptr] <= grant_id;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (ctrl_readdatavalid && fifo_empty)
        err_rdv <= 1'b1;
    end
  end

endmodule
